// File: rtl/line_pixel_fetcher.sv
// line_pixel_fetcher: prefetches one raster line of framebuffer words
// into a small in-order FIFO and serialises them into 4-bit pixels.
module line_pixel_fetcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int WORDS_PER_LINE = 160,
  parameter int ACTIVE_H = 480,
  parameter int ADDR_BITS = 16,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [11:0]   x,
  input  logic [9:0]           y,
  input  logic                 active,
  input  logic                 new_line,
  input  logic                 new_frame,
  output logic                 rd_req,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_ack,
  input  logic                 rd_valid,
  input  logic [15:0]          rd_data,
  output logic [3:0]           pixel,
  output logic                 pixel_valid,
  output logic                 underrun
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = $clog2(WORDS_PER_LINE + 1);
  localparam int SW = CW + 2;
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [9:0] YMAX = 10'(ACTIVE_H);
  localparam logic [WW-1:0] WMAX = WW'(WORDS_PER_LINE);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state_q, state_d;

  logic [15:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count, outstanding, discard;
  logic [WW-1:0]        word_idx;
  logic [ADDR_BITS-1:0] line_addr;
  logic [SW-1:0]        credit;
  logic [15:0]          head;
  logic [3:0]           nib;
  logic                 flush, acked, push, pop, empty, start;
  logic                 slot_end;
  logic                 unused_x;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign unused_x = ^x[11:3];
  assign flush    = new_line | new_frame;
  assign acked    = (state_q == REQ) & rd_ack;
  assign empty    = (count == '0);
  assign slot_end = active & (x[2:0] == 3'd7);
  assign push     = rd_valid & ~flush & (discard == '0);
  assign pop      = slot_end & ~empty;
  assign head     = mem[rd_ptr];
  assign nib      = head[{x[2:1], 2'b00} +: 4];
  assign rd_req   = (state_q == REQ);

  // Credit covers words held, words owed and stale words still to drop.
  assign credit = SW'(count) + SW'(outstanding) + SW'(discard);
  assign start  = (state_q == IDLE) & (y < YMAX) & (word_idx < WMAX)
                & (credit < SW'(FIFO_DEPTH)) & ~flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ:  if (flush || rd_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr     <= BASE_ADDR;
      line_addr   <= BASE_ADDR;
      word_idx    <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (start) rd_addr <= line_addr + ADDR_BITS'(word_idx);
      if (flush) begin
        line_addr   <= new_frame ? BASE_ADDR
                     : line_addr + ADDR_BITS'(WORDS_PER_LINE);
        word_idx    <= '0;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        outstanding <= '0;
        discard     <= discard + outstanding
                     + CW'(acked) - CW'(rd_valid);
      end else begin
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop)  rd_ptr <= nxt(rd_ptr);
        if (acked) word_idx <= word_idx + 1'b1;
        count       <= count + CW'(push) - CW'(pop);
        outstanding <= outstanding + CW'(acked) - CW'(push);
        if (rd_valid && discard != '0) discard <= discard - 1'b1;
      end
      pixel_valid <= active;
      pixel       <= (active && !empty) ? nib : 4'd0;
      if (slot_end && empty) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop && count == CW'(FIFO_DEPTH)));
  end

endmodule
